// File: rtl/mini_src_pkg.sv
// Shared Mini-SRC definitions: opcodes, ALU codes, sequencer states,
// step encodings and the control word driven into the datapath.
package mini_src_pkg;

    localparam int ALU_W  = 4;
    localparam int STEP_W = 4;
    localparam int OP_W   = 5;

    // Opcodes as found in IR[31:27]
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

    // ALU operation selects understood by the datapath ALU
    localparam logic [ALU_W-1:0] ALU_ADD = 4'h0;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'h1;
    localparam logic [ALU_W-1:0] ALU_AND = 4'h2;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'h3;
    localparam logic [ALU_W-1:0] ALU_SHR = 4'h4;
    localparam logic [ALU_W-1:0] ALU_SHL = 4'h5;
    localparam logic [ALU_W-1:0] ALU_ROR = 4'h6;
    localparam logic [ALU_W-1:0] ALU_ROL = 4'h7;
    localparam logic [ALU_W-1:0] ALU_MUL = 4'h8;
    localparam logic [ALU_W-1:0] ALU_DIV = 4'h9;
    localparam logic [ALU_W-1:0] ALU_NEG = 4'hA;
    localparam logic [ALU_W-1:0] ALU_NOT = 4'hB;

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_IDLE = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    typedef logic [STEP_W-1:0] step_t;

    localparam step_t T0 = 4'd0;
    localparam step_t T1 = 4'd1;
    localparam step_t T2 = 4'd2;
    localparam step_t T3 = 4'd3;
    localparam step_t T4 = 4'd4;
    localparam step_t T5 = 4'd5;
    localparam step_t T6 = 4'd6;
    localparam step_t T7 = 4'd7;
    localparam step_t T8 = 4'd8;
    localparam step_t T9 = 4'd9;

    // Every control input of the datapath, RAM and select/encode logic
    typedef struct packed {
        logic [ALU_W-1:0] alu_opcode;
        logic reg_clear, mdr_select, inc_pc, gra, grb, grc, ba_read;
        logic regfile_read, hi_read, lo_read, z_hi_read, z_lo_read;
        logic pc_read, mdr_read, inport_read, c_read, mem_read;
        logic regfile_write, hi_write, lo_write, z_write, pc_write;
        logic mdr_write, ir_write, y_write, mar_write, mem_write, outport_write;
        logic con_write, run;
    } ctrl_t;

    // ALU operation applied in the Zin step of an opcode
    function automatic logic [ALU_W-1:0] alu_of(input logic [OP_W-1:0] op);
        logic [ALU_W-1:0] code;
        code = ALU_ADD;
        case (op)
            OP_SUB:          code = ALU_SUB;
            OP_SHR:          code = ALU_SHR;
            OP_SHL:          code = ALU_SHL;
            OP_ROR:          code = ALU_ROR;
            OP_ROL:          code = ALU_ROL;
            OP_AND, OP_ANDI: code = ALU_AND;
            OP_OR,  OP_ORI:  code = ALU_OR;
            OP_MUL:          code = ALU_MUL;
            OP_DIV:          code = ALU_DIV;
            OP_NEG:          code = ALU_NEG;
            OP_NOT:          code = ALU_NOT;
            default:         code = ALU_ADD;
        endcase
        return code;
    endfunction

    // Final step of an instruction; opcodes without an execute phase end at T3
    function automatic step_t last_step_of(input logic [OP_W-1:0] op);
        step_t s;
        s = T3;
        case (op)
            OP_LD:                                 s = T9;
            OP_ST:                                 s = T8;
            OP_MUL, OP_DIV, OP_BR:                 s = T7;
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR,
            OP_ROL, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
            OP_ORI, OP_LDI:                        s = T6;
            OP_NEG, OP_NOT:                        s = T5;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: s = T4;
            OP_NOP, OP_JAL, OP_HALT:               s = T3;
            default:                               s = T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cu_step_decode.sv
// Combinational step decoder: turns (state, step, opcode, branch flag)
// into the full Moore control word for the current cycle.
module cu_step_decode
    import mini_src_pkg::*;
(
    input  state_e          i_state,
    input  step_t           i_step,
    input  logic [OP_W-1:0] i_opcode,
    input  logic            i_con,
    output ctrl_t           o_ctrl
);

    logic [ALU_W-1:0] w_alu;
    logic             w_is_imm;

    assign w_alu    = alu_of(i_opcode);
    assign w_is_imm = (i_opcode == OP_ADDI) || (i_opcode == OP_ANDI) || (i_opcode == OP_ORI);

    // Decode one control word per step; anything not named stays 0
    always_comb begin
        // NOTE: clearing the whole word first keeps every field assigned on every path, so no latches.
        o_ctrl = '0;
        case (i_state)
            ST_CLR:  o_ctrl.reg_clear = 1'b1;
            ST_IDLE: o_ctrl.run       = 1'b1;
            ST_HALT: o_ctrl.run       = 1'b0;
            ST_EXEC: begin
                o_ctrl.run = 1'b1;
                case (i_step)
                    T0: begin
                        o_ctrl.pc_read   = 1'b1;
                        o_ctrl.mar_write = 1'b1;
                        o_ctrl.inc_pc    = 1'b1;
                        o_ctrl.pc_write  = 1'b1;
                    end
                    T1: o_ctrl.mem_read = 1'b1;
                    T2: begin
                        o_ctrl.mdr_select = 1'b1;
                        o_ctrl.mdr_write  = 1'b1;
                    end
                    T3: begin
                        o_ctrl.mdr_read = 1'b1;
                        o_ctrl.ir_write = 1'b1;
                    end
                    default: begin
                        case (i_opcode)
                            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
                            OP_ADDI, OP_ANDI, OP_ORI: begin
                                case (i_step)
                                    T4: begin
                                        o_ctrl.grb          = 1'b1;
                                        o_ctrl.regfile_read = 1'b1;
                                        o_ctrl.y_write      = 1'b1;
                                    end
                                    T5: begin
                                        o_ctrl.c_read       = w_is_imm;
                                        o_ctrl.grc          = !w_is_imm;
                                        o_ctrl.regfile_read = !w_is_imm;
                                        o_ctrl.alu_opcode   = w_alu;
                                        o_ctrl.z_write      = 1'b1;
                                    end
                                    T6: begin
                                        o_ctrl.z_lo_read     = 1'b1;
                                        o_ctrl.gra           = 1'b1;
                                        o_ctrl.regfile_write = 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                            OP_LDI, OP_LD, OP_ST: begin
                                case (i_step)
                                    T4: begin
                                        o_ctrl.grb     = 1'b1;
                                        o_ctrl.ba_read = 1'b1;
                                        o_ctrl.y_write = 1'b1;
                                    end
                                    T5: begin
                                        o_ctrl.c_read  = 1'b1;
                                        o_ctrl.z_write = 1'b1;
                                    end
                                    T6: begin
                                        o_ctrl.z_lo_read = 1'b1;
                                        if (i_opcode == OP_LDI) begin
                                            o_ctrl.gra           = 1'b1;
                                            o_ctrl.regfile_write = 1'b1;
                                        end else begin
                                            o_ctrl.mar_write = 1'b1;
                                        end
                                    end
                                    T7: begin
                                        if (i_opcode == OP_LD) begin
                                            o_ctrl.mem_read = 1'b1;
                                        end else if (i_opcode == OP_ST) begin
                                            o_ctrl.gra          = 1'b1;
                                            o_ctrl.regfile_read = 1'b1;
                                            o_ctrl.mdr_write    = 1'b1;
                                        end
                                    end
                                    T8: begin
                                        if (i_opcode == OP_LD) begin
                                            o_ctrl.mdr_select = 1'b1;
                                            o_ctrl.mdr_write  = 1'b1;
                                        end else if (i_opcode == OP_ST) begin
                                            o_ctrl.mem_write = 1'b1;
                                        end
                                    end
                                    T9: begin
                                        if (i_opcode == OP_LD) begin
                                            o_ctrl.mdr_read      = 1'b1;
                                            o_ctrl.gra           = 1'b1;
                                            o_ctrl.regfile_write = 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            OP_MUL, OP_DIV: begin
                                case (i_step)
                                    T4: begin
                                        o_ctrl.gra          = 1'b1;
                                        o_ctrl.regfile_read = 1'b1;
                                        o_ctrl.y_write      = 1'b1;
                                    end
                                    T5: begin
                                        o_ctrl.grb          = 1'b1;
                                        o_ctrl.regfile_read = 1'b1;
                                        o_ctrl.alu_opcode   = w_alu;
                                        o_ctrl.z_write      = 1'b1;
                                    end
                                    T6: begin
                                        o_ctrl.z_lo_read = 1'b1;
                                        o_ctrl.lo_write  = 1'b1;
                                    end
                                    T7: begin
                                        o_ctrl.z_hi_read = 1'b1;
                                        o_ctrl.hi_write  = 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                            OP_NEG, OP_NOT: begin
                                case (i_step)
                                    T4: begin
                                        o_ctrl.grb          = 1'b1;
                                        o_ctrl.regfile_read = 1'b1;
                                        o_ctrl.alu_opcode   = w_alu;
                                        o_ctrl.z_write      = 1'b1;
                                    end
                                    T5: begin
                                        o_ctrl.z_lo_read     = 1'b1;
                                        o_ctrl.gra           = 1'b1;
                                        o_ctrl.regfile_write = 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                            OP_BR: begin
                                case (i_step)
                                    T4: begin
                                        o_ctrl.gra          = 1'b1;
                                        o_ctrl.regfile_read = 1'b1;
                                        o_ctrl.con_write    = 1'b1;
                                    end
                                    T5: begin
                                        o_ctrl.pc_read = 1'b1;
                                        o_ctrl.y_write = 1'b1;
                                    end
                                    T6: begin
                                        o_ctrl.c_read  = 1'b1;
                                        o_ctrl.z_write = 1'b1;
                                    end
                                    T7: begin
                                        // Target is always computed; PC only loads when taken
                                        o_ctrl.z_lo_read = 1'b1;
                                        o_ctrl.pc_write  = i_con;
                                    end
                                    default: ;
                                endcase
                            end
                            OP_JR: if (i_step == T4) begin
                                o_ctrl.gra          = 1'b1;
                                o_ctrl.regfile_read = 1'b1;
                                o_ctrl.pc_write     = 1'b1;
                            end
                            OP_IN: if (i_step == T4) begin
                                o_ctrl.inport_read   = 1'b1;
                                o_ctrl.gra           = 1'b1;
                                o_ctrl.regfile_write = 1'b1;
                            end
                            OP_OUT: if (i_step == T4) begin
                                o_ctrl.gra           = 1'b1;
                                o_ctrl.regfile_read  = 1'b1;
                                o_ctrl.outport_write = 1'b1;
                            end
                            OP_MFHI: if (i_step == T4) begin
                                o_ctrl.hi_read       = 1'b1;
                                o_ctrl.gra           = 1'b1;
                                o_ctrl.regfile_write = 1'b1;
                            end
                            OP_MFLO: if (i_step == T4) begin
                                o_ctrl.lo_read       = 1'b1;
                                o_ctrl.gra           = 1'b1;
                                o_ctrl.regfile_write = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Mini-SRC control sequencer: CLR/IDLE/EXEC/HALT state machine with a
// step counter; the control word itself comes from cu_step_decode.
module control_unit
    import mini_src_pkg::*;
(
    input  logic             clk,
    input  logic             in_reset_n,
    input  logic             in_run,
    input  logic [31:0]      in_ir,
    input  logic             in_con,
    output logic [ALU_W-1:0] out_alu_opcode,
    output logic             out_reg_clear,
    output logic             out_mdr_select,
    output logic             out_inc_pc,
    output logic             out_gra,
    output logic             out_grb,
    output logic             out_grc,
    output logic             out_ba_read,
    output logic             out_regfile_read,
    output logic             out_hi_read,
    output logic             out_lo_read,
    output logic             out_z_hi_read,
    output logic             out_z_lo_read,
    output logic             out_pc_read,
    output logic             out_mdr_read,
    output logic             out_inport_read,
    output logic             out_c_read,
    output logic             out_mem_read,
    output logic             out_regfile_write,
    output logic             out_hi_write,
    output logic             out_lo_write,
    output logic             out_z_write,
    output logic             out_pc_write,
    output logic             out_mdr_write,
    output logic             out_ir_write,
    output logic             out_y_write,
    output logic             out_mar_write,
    output logic             out_mem_write,
    output logic             out_outport_write,
    output logic             out_con_write,
    output logic             out_run
);

    state_e          r_state;
    state_e          w_state_next;
    step_t           r_step;
    step_t           w_step_next;
    logic [OP_W-1:0] w_opcode;
    logic            w_last;
    logic            w_unused_ir;
    ctrl_t           w_ctrl;

    // Only the opcode field steers sequencing; operand fields go to select/encode.
    // The no-execute opcodes are recognised at T3, so the opcode on in_ir must
    // already be the incoming instruction's by the end of that step.
    assign w_opcode    = in_ir[31:27];
    assign w_unused_ir = ^in_ir[26:0];
    assign w_last      = (r_step >= last_step_of(w_opcode));

    // State and step registers; reset aborts any instruction at once
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state <= ST_CLR;
            r_step  <= T0;
        end else begin
            // NOTE: non-blocking updates so both registers see pre-edge values of each other.
            r_state <= w_state_next;
            r_step  <= w_step_next;
        end
    end

    // Next state: fetch/execute sequencing, instruction end per in_run, halt trap
    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        case (r_state)
            ST_CLR: begin
                w_state_next = ST_IDLE;
                w_step_next  = T0;
            end
            ST_IDLE: begin
                w_step_next = T0;
                if (in_run) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_last) begin
                    w_step_next = T0;
                    if (w_opcode == OP_HALT) begin
                        w_state_next = ST_HALT;
                    end else if (in_run) begin
                        w_state_next = ST_EXEC;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_step_next = r_step + step_t'(1);
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
                w_step_next  = T0;
            end
            default: begin
                w_state_next = ST_CLR;
                w_step_next  = T0;
            end
        endcase
    end

    cu_step_decode u_step_decode (
        .i_state  (r_state),
        .i_step   (r_step),
        .i_opcode (w_opcode),
        .i_con    (in_con),
        .o_ctrl   (w_ctrl)
    );

    assign out_alu_opcode    = w_ctrl.alu_opcode;
    assign out_reg_clear     = w_ctrl.reg_clear;
    assign out_mdr_select    = w_ctrl.mdr_select;
    assign out_inc_pc        = w_ctrl.inc_pc;
    assign out_gra           = w_ctrl.gra;
    assign out_grb           = w_ctrl.grb;
    assign out_grc           = w_ctrl.grc;
    assign out_ba_read       = w_ctrl.ba_read;
    assign out_regfile_read  = w_ctrl.regfile_read;
    assign out_hi_read       = w_ctrl.hi_read;
    assign out_lo_read       = w_ctrl.lo_read;
    assign out_z_hi_read     = w_ctrl.z_hi_read;
    assign out_z_lo_read     = w_ctrl.z_lo_read;
    assign out_pc_read       = w_ctrl.pc_read;
    assign out_mdr_read      = w_ctrl.mdr_read;
    assign out_inport_read   = w_ctrl.inport_read;
    assign out_c_read        = w_ctrl.c_read;
    assign out_mem_read      = w_ctrl.mem_read;
    assign out_regfile_write = w_ctrl.regfile_write;
    assign out_hi_write      = w_ctrl.hi_write;
    assign out_lo_write      = w_ctrl.lo_write;
    assign out_z_write       = w_ctrl.z_write;
    assign out_pc_write      = w_ctrl.pc_write;
    assign out_mdr_write     = w_ctrl.mdr_write;
    assign out_ir_write      = w_ctrl.ir_write;
    assign out_y_write       = w_ctrl.y_write;
    assign out_mar_write     = w_ctrl.mar_write;
    assign out_mem_write     = w_ctrl.mem_write;
    assign out_outport_write = w_ctrl.outport_write;
    assign out_con_write     = w_ctrl.con_write;
    assign out_run           = w_ctrl.run;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver plans each instruction's
// expected per-cycle strobes and queues them; the monitor compares every cycle.
module tb_control_unit;

    localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3;
    localparam logic [4:0] OP_OR = 5'd10, OP_ADDI = 5'd11, OP_ORI = 5'd13;
    localparam logic [4:0] OP_MUL = 5'd14, OP_DIV = 5'd15, OP_NEG = 5'd16, OP_NOT = 5'd17;
    localparam logic [4:0] OP_BR = 5'd18, OP_JR = 5'd19, OP_IN = 5'd21, OP_OUT = 5'd22;
    localparam logic [4:0] OP_MFHI = 5'd23, OP_MFLO = 5'd24, OP_HALT = 5'd26;

    // One bit per strobe, in the bench's own ordering
    localparam logic [29:0] K_REG_CLEAR = 30'h1 << 0,  K_MDR_SEL = 30'h1 << 1,  K_INC_PC = 30'h1 << 2;
    localparam logic [29:0] K_GRA = 30'h1 << 3,  K_GRB = 30'h1 << 4,  K_GRC = 30'h1 << 5,  K_BA_R = 30'h1 << 6;
    localparam logic [29:0] K_RF_R = 30'h1 << 7,  K_HI_R = 30'h1 << 8,  K_LO_R = 30'h1 << 9,  K_ZHI_R = 30'h1 << 10;
    localparam logic [29:0] K_ZLO_R = 30'h1 << 11, K_PC_R = 30'h1 << 12, K_MDR_R = 30'h1 << 13, K_IN_R = 30'h1 << 14;
    localparam logic [29:0] K_C_R = 30'h1 << 15,  K_MEM_R = 30'h1 << 16, K_RF_W = 30'h1 << 17, K_HI_W = 30'h1 << 18;
    localparam logic [29:0] K_LO_W = 30'h1 << 19, K_Z_W = 30'h1 << 20,  K_PC_W = 30'h1 << 21,  K_MDR_W = 30'h1 << 22;
    localparam logic [29:0] K_IR_W = 30'h1 << 23, K_Y_W = 30'h1 << 24,  K_MAR_W = 30'h1 << 25, K_MEM_W = 30'h1 << 26;
    localparam logic [29:0] K_OUT_W = 30'h1 << 27, K_CON_W = 30'h1 << 28, K_RUN = 30'h1 << 29;

    localparam logic [7:0] TAG_CLR = 8'hF0, TAG_IDLE = 8'hF1, TAG_HALT = 8'hF2;

    typedef struct packed {
        logic [29:0] s;
        logic [3:0]  alu;
        logic [7:0]  op;
        logic [3:0]  step;
    } exp_t;

    logic        clk;
    logic        in_reset_n, in_run, in_con;
    logic [31:0] in_ir;
    logic [3:0]  out_alu_opcode;
    logic out_reg_clear, out_mdr_select, out_inc_pc, out_gra, out_grb, out_grc, out_ba_read;
    logic out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read;
    logic out_pc_read, out_mdr_read, out_inport_read, out_c_read, out_mem_read;
    logic out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write;
    logic out_mdr_write, out_ir_write, out_y_write, out_mar_write, out_mem_write, out_outport_write;
    logic out_con_write, out_run;

    logic [29:0] dut_word;
    exp_t        exp_q[$];
    exp_t        plan[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    control_unit dut (
        .clk(clk), .in_reset_n(in_reset_n), .in_run(in_run), .in_ir(in_ir), .in_con(in_con),
        .out_alu_opcode(out_alu_opcode), .out_reg_clear(out_reg_clear), .out_mdr_select(out_mdr_select),
        .out_inc_pc(out_inc_pc), .out_gra(out_gra), .out_grb(out_grb), .out_grc(out_grc),
        .out_ba_read(out_ba_read), .out_regfile_read(out_regfile_read), .out_hi_read(out_hi_read),
        .out_lo_read(out_lo_read), .out_z_hi_read(out_z_hi_read), .out_z_lo_read(out_z_lo_read),
        .out_pc_read(out_pc_read), .out_mdr_read(out_mdr_read), .out_inport_read(out_inport_read),
        .out_c_read(out_c_read), .out_mem_read(out_mem_read), .out_regfile_write(out_regfile_write),
        .out_hi_write(out_hi_write), .out_lo_write(out_lo_write), .out_z_write(out_z_write),
        .out_pc_write(out_pc_write), .out_mdr_write(out_mdr_write), .out_ir_write(out_ir_write),
        .out_y_write(out_y_write), .out_mar_write(out_mar_write), .out_mem_write(out_mem_write),
        .out_outport_write(out_outport_write), .out_con_write(out_con_write), .out_run(out_run)
    );

    assign dut_word = {out_run, out_con_write, out_outport_write, out_mem_write, out_mar_write,
                       out_y_write, out_ir_write, out_mdr_write, out_pc_write, out_z_write,
                       out_lo_write, out_hi_write, out_regfile_write, out_mem_read, out_c_read,
                       out_inport_read, out_mdr_read, out_pc_read, out_z_lo_read, out_z_hi_read,
                       out_lo_read, out_hi_read, out_regfile_read, out_ba_read, out_grc, out_grb,
                       out_gra, out_inc_pc, out_mdr_select, out_reg_clear};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h want %h", name, cyc, got, want);
        end
    endtask

    function automatic logic [3:0] alu_for(input logic [4:0] op);
        case (op)
            5'd4:  return 4'h1;  // sub
            5'd5:  return 4'h4;  // shr
            5'd6:  return 4'h5;  // shl
            5'd7:  return 4'h6;  // ror
            5'd8:  return 4'h7;  // rol
            5'd9:  return 4'h2;  // and
            5'd10: return 4'h3;  // or
            5'd12: return 4'h2;  // andi
            5'd13: return 4'h3;  // ori
            5'd14: return 4'h8;  // mul
            5'd15: return 4'h9;  // div
            5'd16: return 4'hA;  // neg
            5'd17: return 4'hB;  // not
            default: return 4'h0;
        endcase
    endfunction

    function automatic exp_t mk(input logic [29:0] s, input logic [3:0] alu, input logic [7:0] op, input int step);
        exp_t e;
        e.s = s; e.alu = alu; e.op = op; e.step = 4'(step);
        return e;
    endfunction

    function automatic void add_step(input logic [29:0] s, input logic [3:0] alu, input logic [4:0] op, input int step);
        plan.push_back(mk(s | K_RUN, alu, 8'(op), step));
    endfunction

    // Expected strobes for one whole instruction, written straight from the step tables
    function automatic void plan_instr(input logic [4:0] op, input logic con);
        logic [3:0] a;
        a = alu_for(op);
        plan.delete();
        add_step(K_PC_R | K_MAR_W | K_INC_PC | K_PC_W, 4'h0, op, 0);
        add_step(K_MEM_R, 4'h0, op, 1);
        add_step(K_MDR_SEL | K_MDR_W, 4'h0, op, 2);
        add_step(K_MDR_R | K_IR_W, 4'h0, op, 3);
        if (op >= OP_ADD && op <= OP_ORI) begin
            add_step(K_GRB | K_RF_R | K_Y_W, 4'h0, op, 4);
            add_step(((op >= OP_ADDI) ? K_C_R : (K_GRC | K_RF_R)) | K_Z_W, a, op, 5);
            add_step(K_ZLO_R | K_GRA | K_RF_W, 4'h0, op, 6);
        end else if (op == OP_LDI || op == OP_LD || op == OP_ST) begin
            add_step(K_GRB | K_BA_R | K_Y_W, 4'h0, op, 4);
            add_step(K_C_R | K_Z_W, 4'h0, op, 5);
            if (op == OP_LDI) begin
                add_step(K_ZLO_R | K_GRA | K_RF_W, 4'h0, op, 6);
            end else if (op == OP_LD) begin
                add_step(K_ZLO_R | K_MAR_W, 4'h0, op, 6);
                add_step(K_MEM_R, 4'h0, op, 7);
                add_step(K_MDR_SEL | K_MDR_W, 4'h0, op, 8);
                add_step(K_MDR_R | K_GRA | K_RF_W, 4'h0, op, 9);
            end else begin
                add_step(K_ZLO_R | K_MAR_W, 4'h0, op, 6);
                add_step(K_GRA | K_RF_R | K_MDR_W, 4'h0, op, 7);
                add_step(K_MEM_W, 4'h0, op, 8);
            end
        end else if (op == OP_MUL || op == OP_DIV) begin
            add_step(K_GRA | K_RF_R | K_Y_W, 4'h0, op, 4);
            add_step(K_GRB | K_RF_R | K_Z_W, a, op, 5);
            add_step(K_ZLO_R | K_LO_W, 4'h0, op, 6);
            add_step(K_ZHI_R | K_HI_W, 4'h0, op, 7);
        end else if (op == OP_NEG || op == OP_NOT) begin
            add_step(K_GRB | K_RF_R | K_Z_W, a, op, 4);
            add_step(K_ZLO_R | K_GRA | K_RF_W, 4'h0, op, 5);
        end else if (op == OP_BR) begin
            add_step(K_GRA | K_RF_R | K_CON_W, 4'h0, op, 4);
            add_step(K_PC_R | K_Y_W, 4'h0, op, 5);
            add_step(K_C_R | K_Z_W, 4'h0, op, 6);
            add_step(K_ZLO_R | (con ? K_PC_W : 30'h0), 4'h0, op, 7);
        end else if (op == OP_JR) begin
            add_step(K_GRA | K_RF_R | K_PC_W, 4'h0, op, 4);
        end else if (op == OP_IN) begin
            add_step(K_IN_R | K_GRA | K_RF_W, 4'h0, op, 4);
        end else if (op == OP_OUT) begin
            add_step(K_GRA | K_RF_R | K_OUT_W, 4'h0, op, 4);
        end else if (op == OP_MFHI) begin
            add_step(K_HI_R | K_GRA | K_RF_W, 4'h0, op, 4);
        end else if (op == OP_MFLO) begin
            add_step(K_LO_R | K_GRA | K_RF_W, 4'h0, op, 4);
        end
    endfunction

    // Queue the expected word for the cycle now starting, then move to the next cycle
    task automatic tick(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n_low);
        in_reset_n = 1'b0;
        repeat (n_low) tick(mk(K_REG_CLEAR, 4'h0, TAG_CLR, 0));
        in_reset_n = 1'b1;
        tick(mk(K_REG_CLEAR, 4'h0, TAG_CLR, 0));
    endtask

    task automatic idle(input int n_wait);
        in_run = 1'b0;
        repeat (n_wait) tick(mk(K_RUN, 4'h0, TAG_IDLE, 0));
        in_run = 1'b1;
        tick(mk(K_RUN, 4'h0, TAG_IDLE, 0));
    endtask

    task automatic halt_for(input int n);
        repeat (n) begin
            in_run = 1'($urandom);
            tick(mk(30'h0, 4'h0, TAG_HALT, 0));
        end
    endtask

    // Run one instruction; abort_at >= 0 stops before queuing that step
    task automatic run_instr(input logic [4:0] op, input logic con, input logic run_after, input int abort_at);
        plan_instr(op, con);
        in_ir  = {op, 27'($urandom)};
        in_con = con;
        for (int i = 0; i < plan.size(); i++) begin
            if (i == abort_at) return;
            in_run = (i == plan.size() - 1) ? run_after : 1'($urandom);
            tick(plan[i]);
        end
    endtask

    task automatic instr(input logic [4:0] op, input logic con, input logic run_after);
        run_instr(op, con, run_after, -1);
        if (!run_after) idle(int'($urandom_range(0, 3)));
    endtask

    task automatic rand_instr();
        logic [4:0] op;
        op = 5'($urandom_range(0, 31));
        while (op == OP_HALT) op = 5'($urandom_range(0, 31));
        instr(op, 1'($urandom), ($urandom_range(0, 3) != 0));
    endtask

    // Monitor: the control word is presented every cycle; compare mid-cycle
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("strobes op=%0h T%0d", e.op, e.step), 32'(dut_word), 32'(e.s));
                check($sformatf("alu op=%0h T%0d", e.op, e.step), 32'(out_alu_opcode), 32'(e.alu));
            end
        end
    end

    // Driver
    initial begin
        in_reset_n = 1'b0;
        in_run     = 1'b1;
        in_ir      = 32'h0;
        in_con     = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);
        idle(0);
        instr(OP_ADD, 1'b0, 1'b1);
        instr(OP_LD, 1'b0, 1'b1);
        instr(OP_BR, 1'b0, 1'b1);
        instr(OP_BR, 1'b1, 1'b1);
        instr(OP_ADD, 1'b0, 1'b0);
        instr(5'b11111, 1'b0, 1'b1);
        instr(OP_MUL, 1'b0, 1'b1);
        instr(OP_NOT, 1'b0, 1'b1);
        instr(OP_ST, 1'b1, 1'b1);
        run_instr(OP_LD, 1'b0, 1'b1, 7);
        do_reset(2);
        idle(0);
        repeat (120) rand_instr();
        run_instr(OP_HALT, 1'b0, 1'b1, -1);
        halt_for(20);
        do_reset(1);
        idle(0);
        instr(OP_DIV, 1'b0, 1'b1);
        instr(OP_OR, 1'b0, 1'b1);
        instr(OP_NEG, 1'b0, 1'b1);
        repeat (30) rand_instr();
        @(negedge clk);
        #1;
        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so a stuck run still reports
    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout want finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
